// File: rtl/sync_frame_tx_if.sv
// Payload handshake bundle for sync_frame_tx.
//   in_valid : producer offers a payload word
//   in_data  : payload word, DATA_W bits
//   in_ready : transmitter can take a word this cycle
// master = payload producer, slave = transmitter.
interface sync_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sync_frame_tx.sv
// Bit-serial frame transmitter.
// Takes a payload word over a valid/ready handshake. It then sends one bit
// per clock on x: the sync word, then the payload, both MSB first. After
// that it holds the line at IDLE_BIT for GAP cycles before it accepts the
// next word.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous reset, active high; aborts any frame in flight
//   in_if : payload handshake (slave side); in_ready is high only in IDLE
//   x     : serial line, registered
//   frame : high while x carries a sync or payload bit, registered
//   done  : high while x carries the last payload bit, registered
module sync_frame_tx #(
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC     = 4'b1101,
    parameter int                DATA_W   = 8,
    parameter int                GAP      = 2,
    parameter logic              IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    sync_frame_tx_if.slave    in_if,
    output logic              x,
    output logic              frame,
    output logic              done
);

    localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_MAX = (MAX_SD > GAP) ? MAX_SD : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;      // bits already placed on x in this phase
    logic [DATA_W-1:0] shift_reg;    // payload, MSB is the next bit to send
    logic [SYNC_W-1:0] sync_shifted;

    assign in_if.in_ready = (state_reg == S_IDLE);

    // The MSB of this vector is the sync bit that follows the cnt_reg bits
    // already sent.
    assign sync_shifted = SYNC << cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            x         <= IDLE_BIT;
            frame     <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_if.in_valid) begin
                        // The first sync bit goes out on the cycle after the accept.
                        shift_reg <= in_if.in_data;
                        state_reg <= S_SYNC;
                        cnt_reg   <= CNT_W'(1);
                        x         <= SYNC[SYNC_W-1];
                        frame     <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                S_SYNC: begin
                    if (cnt_reg == CNT_W'(SYNC_W)) begin
                        state_reg <= S_DATA;
                        cnt_reg   <= CNT_W'(1);
                        x         <= shift_reg[DATA_W-1];
                        shift_reg <= shift_reg << 1;
                        done      <= (DATA_W == 1);
                    end else begin
                        x       <= sync_shifted[SYNC_W-1];
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_reg == CNT_W'(DATA_W)) begin
                        x     <= IDLE_BIT;
                        frame <= 1'b0;
                        done  <= 1'b0;
                        if (GAP > 0) begin
                            state_reg <= S_GAP;
                            cnt_reg   <= CNT_W'(1);
                        end else begin
                            state_reg <= S_IDLE;
                            cnt_reg   <= '0;
                        end
                    end else begin
                        x         <= shift_reg[DATA_W-1];
                        shift_reg <= shift_reg << 1;
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                        done      <= (cnt_reg == CNT_W'(DATA_W - 1));
                    end
                end
                S_GAP: begin
                    if (cnt_reg == CNT_W'(GAP)) begin
                        state_reg <= S_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_frame_tx.sv
module tb_sync_frame_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_frame_tx_if #(.DATA_W(8))  bus();
    sync_frame_tx_if #(.DATA_W(16)) bus2();

    logic x, frame, done;
    logic x2, frame2, done2;

    sync_frame_tx dut (
        .clk   (clk),
        .rst   (rst),
        .in_if (bus.slave),
        .x     (x),
        .frame (frame),
        .done  (done)
    );

    sync_frame_tx #(
        .SYNC_W   (8),
        .SYNC     (8'hB2),
        .DATA_W   (16),
        .GAP      (0),
        .IDLE_BIT (1'b0)
    ) dut2 (
        .clk   (clk),
        .rst   (rst),
        .in_if (bus2.slave),
        .x     (x2),
        .frame (frame2),
        .done  (done2)
    );

    typedef struct packed {
        logic x;
        logic frame;
        logic done;
        logic ready;
    } rec_t;

    rec_t q[$];
    rec_t q2[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Expected per-cycle outputs for one default frame, starting the cycle
    // after the accept: 4 sync bits, 8 payload bits, 2 gap cycles, then ready.
    function automatic void push_a(input logic [7:0] d);
        logic [3:0] s;
        s = 4'b1101;
        for (int i = 3; i >= 0; i--) q.push_back('{x: s[i], frame: 1'b1, done: 1'b0, ready: 1'b0});
        for (int i = 7; i >= 0; i--) q.push_back('{x: d[i], frame: 1'b1, done: (i == 0), ready: 1'b0});
        for (int i = 0; i < 2; i++)  q.push_back('{x: 1'b0, frame: 1'b0, done: 1'b0, ready: 1'b0});
        q.push_back('{x: 1'b0, frame: 1'b0, done: 1'b0, ready: 1'b1});
    endfunction

    // Swept instance: 8 sync bits (B2), 16 payload bits, no gap, one idle cycle.
    function automatic void push_b(input logic [15:0] d);
        logic [7:0] s;
        s = 8'hB2;
        for (int i = 7; i >= 0; i--)  q2.push_back('{x: s[i], frame: 1'b1, done: 1'b0, ready: 1'b0});
        for (int i = 15; i >= 0; i--) q2.push_back('{x: d[i], frame: 1'b1, done: (i == 0), ready: 1'b0});
        q2.push_back('{x: 1'b0, frame: 1'b0, done: 1'b0, ready: 1'b1});
    endfunction

    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (x !== 1'b0)            begin n_err++; $display("FAIL reset_x: got %b required 0", x); end
        n_cmp++; if (frame !== 1'b0)        begin n_err++; $display("FAIL reset_frame: got %b required 0", frame); end
        n_cmp++; if (done !== 1'b0)         begin n_err++; $display("FAIL reset_done: got %b required 0", done); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", bus.in_ready); end
        n_cmp++; if ({x2, frame2, done2, bus2.in_ready} !== 4'b0001)
            begin n_err++; $display("FAIL reset_dut2: got %b required 0001", {x2, frame2, done2, bus2.in_ready}); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        $display("reset: outputs idle, in_ready=%b", bus.in_ready);
    endtask

    task automatic test_single();
        rec_t got, exp;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_pre: got %b required 1", bus.in_ready); end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        push_a(8'hA5);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int j = 1; j <= 15; j++) begin
            got = '{x: x, frame: frame, done: done, ready: bus.in_ready};
            exp = q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL single k+%0d: got x/frame/done/ready=%b required %b", j, got, exp);
            end
            if (j < 15) @(negedge clk);
        end
        $display("single: frame 8'hA5 checked over 15 cycles");
    endtask

    task automatic test_back_to_back();
        rec_t got, exp;
        int acc[$];
        int low_cnt;
        low_cnt = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        for (int cyc = 0; cyc < 60 && !(acc.size() == 2 && q.size() == 0); cyc++) begin
            if (q.size() > 0) begin
                got = '{x: x, frame: frame, done: done, ready: bus.in_ready};
                exp = q.pop_front();
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL b2b cycle %0d: got x/frame/done/ready=%b required %b", cyc, got, exp);
                end
            end
            if (acc.size() == 1 && bus.in_ready === 1'b0) low_cnt++;
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                acc.push_back(cyc);
                push_a(bus.in_data);
            end
            @(negedge clk);
            if (acc.size() == 1) bus.in_data = 8'hC3;
            if (acc.size() >= 2) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (acc.size() != 2 || q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_accepts: got %0d accepts, %0d pending required 2 accepts, 0 pending", acc.size(), q.size());
        end else begin
            n_cmp++;
            if (acc[1] - acc[0] != 15) begin n_err++; $display("FAIL b2b_spacing: got %0d required 15", acc[1] - acc[0]); end
        end
        n_cmp++; if (low_cnt != 14) begin n_err++; $display("FAIL b2b_ready_low: got %0d required 14", low_cnt); end
        q.delete();
        $display("back_to_back: 8'h3C then 8'hC3, ready low %0d cycles", low_cnt);
    endtask

    task automatic test_embedded_sync();
        rec_t got, exp;
        logic [3:0] hist;
        int fires[$];
        hist = 4'b0000;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hD0;
        push_a(8'hD0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            got = '{x: x, frame: frame, done: done, ready: bus.in_ready};
            exp = q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL embed k+%0d: got x/frame/done/ready=%b required %b", j, got, exp);
            end
            hist = {hist[2:0], x};
            if (hist == 4'b1101) fires.push_back(j);
            if (j < 15) @(negedge clk);
        end
        n_cmp++;
        if (fires.size() != 2) begin
            n_err++;
            $display("FAIL embed_fire_count: got %0d required 2", fires.size());
        end else begin
            n_cmp++;
            if (fires[0] != 4 || fires[1] != 8) begin
                n_err++;
                $display("FAIL embed_fire_pos: got k+%0d,k+%0d required k+4,k+8", fires[0], fires[1]);
            end
        end
        $display("embedded_sync: 8'hD0 detector fires=%0d", fires.size());
    endtask

    task automatic test_reset_mid();
        rec_t got, exp;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        push_a(8'h5A);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            got = '{x: x, frame: frame, done: done, ready: bus.in_ready};
            exp = q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL rstmid k+%0d: got x/frame/done/ready=%b required %b", j, got, exp);
            end
            if (j < 6) @(negedge clk);
        end
        // 6th bit is on x now: reset with a competing valid offer.
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h96;
        q.delete();
        @(negedge clk);
        n_cmp++; if ({x, frame, done, bus.in_ready} !== 4'b0001)
            begin n_err++; $display("FAIL rstmid_after: got x/frame/done/ready=%b required 0001", {x, frame, done, bus.in_ready}); end
        rst = 1'b0;
        push_a(8'h96);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            got = '{x: x, frame: frame, done: done, ready: bus.in_ready};
            exp = q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL rstmid_restart k+%0d: got x/frame/done/ready=%b required %b", j, got, exp);
            end
            if (j < 15) @(negedge clk);
        end
        $display("reset_mid: abort of 8'h5A, restart with 8'h96 checked");
    endtask

    task automatic test_sweep();
        rec_t got, exp;
        int acc[$];
        @(negedge clk);
        bus2.in_valid = 1'b1;
        bus2.in_data  = 16'($urandom);
        for (int cyc = 0; cyc < 120 && !(acc.size() == 3 && q2.size() == 0); cyc++) begin
            if (q2.size() > 0) begin
                got = '{x: x2, frame: frame2, done: done2, ready: bus2.in_ready};
                exp = q2.pop_front();
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL sweep cycle %0d: got x/frame/done/ready=%b required %b", cyc, got, exp);
                end
            end
            if (bus2.in_valid && bus2.in_ready === 1'b1) begin
                acc.push_back(cyc);
                push_b(bus2.in_data);
                $display("sweep: accept %0d data=%h at cycle %0d", acc.size(), bus2.in_data, cyc);
            end
            @(negedge clk);
            if (acc.size() < 3) bus2.in_data = 16'($urandom);
            else                bus2.in_valid = 1'b0;
        end
        bus2.in_valid = 1'b0;
        n_cmp++;
        if (acc.size() != 3 || q2.size() != 0) begin
            n_err++;
            $display("FAIL sweep_accepts: got %0d accepts, %0d pending required 3 accepts, 0 pending", acc.size(), q2.size());
        end else begin
            n_cmp++;
            if (acc[1] - acc[0] != 25 || acc[2] - acc[1] != 25) begin
                n_err++;
                $display("FAIL sweep_period: got %0d,%0d required 25,25", acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_embedded_sync();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_frame_tx.md
Name: sync_frame_tx

Overview:
Serial frame transmitter, the sending end for the bit-serial sync-word detectors (e.g. the 1101 Mealy detector). Accepts a parallel payload word over a valid/ready handshake. Emits one bit per clock: a fixed sync word, then the payload, both MSB first, then a fixed idle gap. Drives the single-bit serial line `x` that a detector samples.

Parameters:
- SYNC_W, 4, sync word width in bits (>=1).
- SYNC, 4'b1101, sync word value, SYNC_W bits, transmitted MSB first.
- DATA_W, 8, payload width in bits (>=1).
- GAP, 2, idle cycles forced after each frame (>=0).
- IDLE_BIT, 1'b0, level driven on `x` when not transmitting.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  payload offered.
- in_data  in  DATA_W  payload word; sampled only on the accepting edge.
- in_ready  out  1  transmitter can accept a payload this cycle.
- x  out  1  serial line, registered.
- frame  out  1  high while `x` carries a sync or payload bit, registered.
- done  out  1  one-cycle pulse, high while `x` carries the last payload bit, registered.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- States: IDLE, SYNC, DATA, GAP. One bit counter, sized for max(SYNC_W, DATA_W, GAP). One DATA_W-bit shift register.
- Reset: on any edge with rst=1, state <= IDLE, counter <= 0, x <= IDLE_BIT, frame <= 0, done <= 0. in_valid is ignored on that edge.
- Reset mid-frame aborts the frame; no remaining bits are sent. in_ready is 1 in the cycle after the reset edge.
- in_ready = (state==IDLE), combinational from state only. It never depends on in_valid.
- Accept: the edge where in_valid & in_ready & !rst. That edge captures in_data and moves to SYNC. in_valid with in_ready=0 has no effect, and data is not queued.
- Output timing (k = accepting edge):
  - Cycles k+1..k+SYNC_W: x = SYNC[SYNC_W-1] down to SYNC[0].
  - Next DATA_W cycles: x = in_data[DATA_W-1] down to in_data[0].
  - frame=1 for all SYNC_W+DATA_W of these cycles.
  - done=1 only during the in_data[0] cycle.
- After the last payload bit, go to GAP: GAP cycles with x=IDLE_BIT, frame=0, in_ready=0. Then IDLE.
- If GAP=0, go straight from DATA to IDLE.
- Minimum accept-to-accept spacing: 1+SYNC_W+DATA_W+GAP cycles. Default is 15.
- The payload is not escaped. A sync pattern inside the payload is transmitted verbatim, and the receiver is responsible for framing.
- x, frame and done change only on rising edges. There are no combinational paths from inputs to them.

Test Plan:
- Single frame, defaults, in_data=8'hA5 accepted at edge k:
  - x over k+1..k+12 = 1,1,0,1,1,0,1,0,0,1,0,1.
  - frame=1 for exactly those 12 cycles; done=1 only at k+12.
  - x=0 with in_ready=0 at k+13..k+14; in_ready=1 at k+15.
- Backpressure: in_valid held high with 8'h3C then 8'hC3.
  - Second accept occurs exactly 15 cycles after the first.
  - in_ready is low for 14 cycles in between; 8'h3C is never retransmitted.
- Overlap/embedded sync: in_data=8'hD0.
  - x stream = 1101 11010000.
  - A reference 1101 overlapping detector model on x fires exactly twice, at k+4 and k+8.
- Reset mid-frame: assert rst for one edge while the 6th bit is on x.
  - Next cycle: x=0, frame=0, done=0, in_ready=1.
  - Any new accept restarts with the sync MSB.
  - in_valid=1 during the rst edge causes no accept.
- Parameter sweep: SYNC_W=8, SYNC=8'hB2, DATA_W=16, GAP=0, in_valid held high.
  - Frames back-to-back with a period of 25 cycles.
  - Exactly one IDLE cycle (x=0, in_ready=1) between frames.
  - done on each 24th frame bit.
